muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide unit.
//   op_e    : operation select as presented on the op bus
//   state_e : sequencer states of muldiv_unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: operand/result bus between the core and the multiply/divide unit.
//   start, op, a, b    : launch request with operands (rd1/rd2)
//   hi_we, lo_we, wd   : MTHI/MTLO writes
//   hi, lo, busy, done : HI/LO contents, stall request, completion pulse
// master = core side, slave = muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : muldiv_if.slave (start/op/a/b, hi_we/lo_we/wd, hi/lo/busy/done)
// One shift-add or restoring shift-subtract step per cycle on magnitudes;
// signs are fixed up in a single final cycle so HI/LO update atomically.
//
// state  | meaning
// S_IDLE | waiting; accepts start or MTHI/MTLO writes
// S_RUN  | WIDTH iteration steps, cnt_q counts 0..WIDTH-1
// S_FIX  | sign correction, HI/LO written at the end of this cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q, neg_q, rneg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic idle, launch, step, fix, busy, last;

  assign last = (cnt_q == CW'(WIDTH-1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    idle   = 1'b0;
    launch = 1'b0;
    step   = 1'b0;
    fix    = 1'b0;
    busy   = 1'b0;
    case (state_q)
      S_IDLE: begin
        idle   = 1'b1;
        launch = bus.start;
      end
      S_RUN: begin
        step = 1'b1;
        busy = 1'b1;
      end
      S_FIX: begin
        fix  = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // operand capture: magnitudes for signed ops, raw values otherwise
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

  // multiply: multiplier sits in the low half and shifts out as the
  // product shifts in from the top
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // divide: partial remainder in the high half, dividend/quotient in the low
  // half. The remainder stays below 2^WIDTH, so bit WIDTH of the difference
  // is a clean borrow, and a zero divisor naturally yields all-ones quotient.
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};

  // sign correction
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  assign prod   = neg_q  ? -acc_q : acc_q;
  assign quo    = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_hi = div_q  ? rem : prod[2*WIDTH-1:WIDTH];
  assign fix_lo = div_q  ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix;
      if (launch) begin
        div_q  <= bus.op[1];
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt_q  <= '0;
        opnd_q <= bus.op[1] ? b_mag : a_mag;
        acc_q  <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
      end else if (step) begin
        acc_q <= div_q ? div_next : mul_next;
        if (!last) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // HI/LO: operation results win; MTHI/MTLO only in IDLE without start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (idle && !bus.start) begin
      if (bus.hi_we) hi_q <= bus.wd;
      if (bus.lo_we) lo_q <= bus.wd;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Launch one op; optionally assert MTHI/MTLO with start, or poke start and
  // writes mid-RUN. Checks busy length, HI/LO hold, done pulse and result.
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit same_cyc_wr, input bit poke);
    logic [31:0] prev_hi, prev_lo;
    int n;
    @(negedge clk);
    prev_hi   = bus.hi;
    prev_lo   = bus.lo;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    if (same_cyc_wr) begin
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wd    = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 1 || n == 32) begin
        chk({tag, " hi_hold"}, {32'd0, bus.hi}, {32'd0, prev_hi});
        chk({tag, " lo_hold"}, {32'd0, bus.lo}, {32'd0, prev_lo});
      end
      if (poke && n == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'hDEAD_BEEF;
      end
      if (poke && n == 6) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    chk({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
    @(negedge clk);
    chk({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wd    = '0;

    repeat (2) @(negedge clk);
    chk("rst hi",   {32'd0, bus.hi}, 64'd0);
    chk("rst lo",   {32'd0, bus.lo}, 64'd0);
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst done", {63'd0, bus.done}, 64'd0);
    reset_n = 1'b1;

    // MTHI alone
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wd    = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi hi", {32'd0, bus.hi}, 64'hA5A5_A5A5);
    chk("mthi lo", {32'd0, bus.lo}, 64'd0);

    // MTHI + MTLO together
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wd    = 32'h0F0F_0F0F;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthilo hi", {32'd0, bus.hi}, 64'h0F0F_0F0F);
    chk("mthilo lo", {32'd0, bus.lo}, 64'h0F0F_0F0F);

    run_op("mult_neg3x5", OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
    run_op("div_neg7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_7_neg2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 1'b0);
    run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,        32'd2,        32'd14,        1'b0, 1'b0);
    run_op("divu_by0",    OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_neg_by0", OP_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'h0000_0001, 1'b0, 1'b0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst busy", {63'd0, bus.busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst hi",   {32'd0, bus.hi}, 64'd0);
    chk("async_rst lo",   {32'd0, bus.lo}, 64'd0);
    chk("async_rst busy", {63'd0, bus.busy}, 64'd0);
    chk("async_rst done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
